// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction-time game consumer: state encoding,
// bus widths and default timing limits.
package reaction_timer_pkg;

    localparam int RAND_W           = 12;
    localparam int RESULT_W         = 14;
    localparam int MIN_DELAY_MS_DEF = 500;
    localparam int MAX_REACT_MS_DEF = 9999;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DELAY = 3'd2,
        GO    = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe: one-cycle tick every CLK_HZ/1000 cycles, restarting
// from zero whenever clear is high.
module ms_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Decoded from the counter alone so the FSM may use it to compute clear.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game round controller: fetches a random delay, counts it out,
// lights GO and measures the player's reaction in milliseconds.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
    parameter int MAX_REACT_MS = MAX_REACT_MS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        react,
    input  logic [11:0] rand_value,
    input  logic        rand_valid,
    output logic        rand_req,
    output logic        led_go,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout
);

    localparam logic [RAND_W-1:0]   MIN_VAL = RAND_W'(MIN_DELAY_MS);
    localparam logic [RESULT_W-1:0] MAX_VAL = RESULT_W'(MAX_REACT_MS);

    state_t              state, state_next;
    logic [RAND_W-1:0]   delay_cnt, delay_cnt_next;
    logic [RESULT_W-1:0] react_cnt, react_cnt_next;
    logic                tick, tick_clear;
    logic                res_load;
    logic [RESULT_W-1:0] res_ms_next;
    logic                res_fs_next, res_to_next;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_next     = state;
        delay_cnt_next = delay_cnt;
        react_cnt_next = react_cnt;
        res_load       = 1'b0;
        res_ms_next    = '0;
        res_fs_next    = 1'b0;
        res_to_next    = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                if (rand_valid && rand_value >= MIN_VAL) begin
                    delay_cnt_next = rand_value;
                    state_next     = DELAY;
                end
            end
            DELAY: begin
                // A react on the very last delay cycle is still a false start.
                if (react) begin
                    res_load    = 1'b1;
                    res_fs_next = 1'b1;
                    state_next  = DONE;
                end else if (tick) begin
                    if (delay_cnt <= RAND_W'(1)) begin
                        delay_cnt_next = '0;
                        react_cnt_next = '0;
                        state_next     = GO;
                    end else begin
                        delay_cnt_next = delay_cnt - RAND_W'(1);
                    end
                end
            end
            GO: begin
                // react is checked first so it wins over a simultaneous timeout.
                if (react) begin
                    res_load    = 1'b1;
                    res_ms_next = react_cnt;
                    state_next  = DONE;
                end else if (react_cnt >= MAX_VAL) begin
                    res_load    = 1'b1;
                    res_ms_next = MAX_VAL;
                    res_to_next = 1'b1;
                    state_next  = DONE;
                end else if (tick) begin
                    react_cnt_next = react_cnt + RESULT_W'(1);
                end
            end
            DONE: begin
                if (start) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase

        // Tick phase runs only inside DELAY/GO and restarts on entry to each.
        tick_clear = (state_next != state) || !(state == DELAY || state == GO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            delay_cnt    <= '0;
            react_cnt    <= '0;
            rand_req     <= 1'b0;
            led_go       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_ms    <= '0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_next;
            delay_cnt    <= delay_cnt_next;
            react_cnt    <= react_cnt_next;
            rand_req     <= (state_next == FETCH);
            led_go       <= (state_next == GO);
            busy         <= !(state_next == IDLE || state_next == DONE);
            result_valid <= res_load;
            if (res_load) begin
                result_ms   <= res_ms_next;
                false_start <= res_fs_next;
                timeout     <= res_to_next;
            end
        end
    end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Consumer side of the random-delay generator in the reaction-time game. On a start press it requests a random delay value, rejects values below the minimum, counts that many milliseconds, lights the GO LED, then measures the player's reaction in milliseconds until the react button is pressed. It sits between the debounced button inputs and the display/score logic, which takes the result.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency; one ms tick every CLK_HZ/1000 cycles
- MIN_DELAY_MS, 500, smallest random delay accepted
- MAX_REACT_MS, 9999, reaction count saturation and timeout value

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse, debounced and synchronized start button
- react  in  1  single-cycle pulse, debounced and synchronized react button
- rand_value  in  12  random delay in ms from the generator
- rand_valid  in  1  rand_value is meaningful this cycle
- rand_req  out  1  level; high while a delay value is wanted
- led_go  out  1  GO indicator
- busy  out  1  high in any state except IDLE and DONE
- result_ms  out  14  last reaction time in ms, held until the next result
- result_valid  out  1  single-cycle pulse when result_ms/false_start/timeout update
- false_start  out  1  last round ended by react before GO
- timeout  out  1  last round hit MAX_REACT_MS

## Operation
- States: IDLE, FETCH, DELAY, GO, DONE.
- IDLE: start -> FETCH. react is ignored.
- FETCH: rand_req=1. Accept the value when rand_valid=1 and rand_value >= MIN_DELAY_MS. Load it into delay_cnt, clear ms phase, then -> DELAY. Values below the minimum are dropped and rand_req stays high.
- DELAY: delay_cnt decrements on each ms tick.
  - When delay_cnt reaches 0 -> GO.
  - A react before that ends the round: false_start=1, timeout=0, result_ms=0, result_valid pulse, -> DONE.
- GO: led_go=1. react_cnt starts at 0 and increments on each ms tick, saturating at MAX_REACT_MS.
  - react -> result_ms=react_cnt, flags 0, result_valid, -> DONE.
  - If react_cnt reaches MAX_REACT_MS with no react: timeout=1, result_ms=MAX_REACT_MS, result_valid, -> DONE.
  - If react and saturation coincide, react wins: timeout=0, result_ms=MAX_REACT_MS.
- DONE: result held. start -> FETCH (new round). react is ignored.
- start while busy is ignored.
- The ms tick counter is free-running only while in DELAY or GO. It clears to 0 on entry to each of those states, so the first tick comes exactly CLK_HZ/1000 cycles after entry.

## Timing
- Reset values:
  - state IDLE
  - rand_req, led_go, busy, result_valid, false_start, timeout: 0
  - result_ms: 0
  - all counters: 0
- All outputs are registered.
- start seen in cycle n: rand_req and busy are high in cycle n+1.
- Valid rand_value accepted in cycle n: state is DELAY in n+1 and rand_req is low in n+1.
- DELAY length is exactly rand_value × CLK_HZ/1000 cycles. led_go rises in the cycle after the final tick.
- react seen in cycle n during GO: result_ms, flags and result_valid update in cycle n+1, led_go falls in n+1, and state is DONE in n+1.
- Reaction resolution is 1 ms, truncated: a react before the first tick reports 0.
- rst asserted mid-round forces the IDLE/reset values immediately, with no result_valid pulse.

## Structure
- Shared package holds:
  - state encoding constants (IDLE=0, FETCH=1, DELAY=2, GO=3, DONE=4, 3 bits)
  - MIN_DELAY_MS and MAX_REACT_MS defaults
  - the 12-bit rand width and 14-bit result width
- One sub-module, ms_tick_gen (parameter CLK_HZ; ports clk, rst, clear, tick). It emits a one-cycle pulse every CLK_HZ/1000 cycles and restarts on clear.
- FSM, delay_cnt and react_cnt live in reaction_timer.

## Test plan
Bench runs CLK_HZ=4000, which gives 4 cycles per ms.
- Normal round: start; rand_value=600 with rand_valid -> led_go rises 2400 cycles after acceptance (+1); react 40 cycles after led_go -> result_ms=10, result_valid one cycle, flags 0.
- Low value rejection: rand_value=499 valid, then 500 valid -> first ignored with rand_req still high; second accepted and led_go after 2000 cycles.
- False start: rand_value=800; react 100 cycles into DELAY -> false_start=1, result_ms=0, led_go never rises, state DONE.
- Timeout: MAX_REACT_MS=20, no react -> timeout=1, result_ms=20 exactly 80 cycles after led_go rises (+1).
- Reset mid-GO: rst pulsed while led_go=1 -> all outputs 0 next edge, no result_valid; a following start begins a fresh FETCH.
- Start while busy / react in IDLE: extra start in DELAY leaves delay timing unchanged; react in IDLE or DONE produces no result_valid.
